// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer controller.
//   state_t     : controller FSM state encoding
//   TIMEOUT_DEF : default ack_ wait limit in cycles (legal range 1..15)
//   CNT_W       : width of the ack_ wait counter
package bus_xfer_pkg;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRIVE = 3'd2,
    ST_RECV  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_END   = 3'd5
  } state_t;

endpackage

// File: rtl/am2907.sv
// Behavioural model of one am2907 quad bus transceiver slice.
//   clk      : system clock; DRCP is treated as a clock enable on it
//   a        : driver register data in
//   drcp     : driver register load strobe
//   be_      : bus enable (drive bus_ from the driver register), active-low
//   rle_     : receiver latch enable, active-low (0 = transparent)
//   oe_      : receiver output enable, active-low
//   bus_in_  : resolved state of the inverting bus lines
//   bus_drv_ : value this slice pulls onto the bus (all ones when released)
//   r        : receiver output (zero when disabled, standing in for hi-Z)
//   odd      : XOR of the driver register while driving, else of receiver data
module am2907 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic             drcp,
  input  logic             be_,
  input  logic             rle_,
  input  logic             oe_,
  input  logic [WIDTH-1:0] bus_in_,
  output logic [WIDTH-1:0] bus_drv_,
  output logic [WIDTH-1:0] r,
  output logic             odd
);

  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] rlat;
  logic [WIDTH-1:0] rx;

  // NOTE: the real part has no reset pin, so these registers are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (drcp)  dreg <= a;
    if (!rle_) rlat <= ~bus_in_;
  end

  // Transparent while rle_=0, holding the last captured value once it rises.
  assign rx       = rle_ ? rlat : ~bus_in_;
  assign r        = oe_ ? '0 : rx;
  assign bus_drv_ = be_ ? '1 : ~dreg;
  assign odd      = be_ ? ^rx : ^dreg;

endmodule

// File: rtl/bus_xfer_tmo.sv
// Ack wait counter for bus_xfer_ctl.
//   clk    : clock
//   rst_   : synchronous active-low reset, clears the count
//   clr    : synchronous clear (wins over en)
//   en     : count one cycle of ack_ still high
//   expire : count has reached TIMEOUT-1
module bus_xfer_tmo
  import bus_xfer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // The FSM leaves the wait state on expiry, so the count never wraps.
  assign expire = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_xfer_ctl.sv
// Single-transfer bus controller driving an am2907 transceiver slice.
//   clk, rst_         : clock, synchronous active-low reset
//   req, wr, wdata    : transfer request, direction (1=write), write data
//   par_in            : expected read parity, sampled with the ack
//   ack_              : active-low slave acknowledge
//   r, odd            : transceiver receiver data and parity
//   a, drcp           : driver register data and load strobe
//   be_, rle_, oe_    : transceiver bus / latch / output enables, active-low
//   rdata             : captured read data
//   busy, done        : in-transfer flag, one-cycle completion pulse
//   perr, tmo         : parity error and ack timeout of the last transfer
module bus_xfer_ctl
  import bus_xfer_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             req,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             par_in,
  input  logic             ack_,
  input  logic [WIDTH-1:0] r,
  input  logic             odd,
  output logic [WIDTH-1:0] a,
  output logic             drcp,
  output logic             be_,
  output logic             rle_,
  output logic             oe_,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             perr,
  output logic             tmo
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_nx, rdata_nx;
  logic             drcp_nx, be_nx, rle_nx, oe_nx;
  logic             busy_nx, done_nx, perr_nx, tmo_nx;
  logic             par_cap, par_nx;
  logic             waiting, expire;

  // The counter runs only in the two ack-wait states and sits at zero
  // everywhere else, which gives the clear-on-entry behaviour for free.
  assign waiting = (state == ST_DRIVE) || (state == ST_RECV);

  bus_xfer_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst_   (rst_),
    .clr    (!waiting),
    .en     (waiting && ack_),
    .expire (expire)
  );

  // Outputs are computed for the next state and registered with it, so
  // every output is a flop and the enables change on the state edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_nx = state;
    a_nx     = a;
    rdata_nx = rdata;
    drcp_nx  = 1'b0;
    be_nx    = 1'b1;
    rle_nx   = 1'b1;
    oe_nx    = 1'b1;
    busy_nx  = busy;
    done_nx  = 1'b0;
    perr_nx  = perr;
    tmo_nx   = tmo;
    par_nx   = par_cap;

    unique case (state)
      ST_IDLE: begin
        if (req) begin
          busy_nx = 1'b1;
          perr_nx = 1'b0;
          tmo_nx  = 1'b0;
          if (wr) begin
            state_nx = ST_LOAD;
            a_nx     = wdata;
            drcp_nx  = 1'b1;
          end else begin
            state_nx = ST_RECV;
            rle_nx   = 1'b0;
            oe_nx    = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        state_nx = ST_DRIVE;
        be_nx    = 1'b0;
      end
      ST_DRIVE: begin
        // Ack is tested before expiry so a same-cycle ack is not a timeout.
        if (!ack_) begin
          state_nx = ST_END;
          done_nx  = 1'b1;
        end else if (expire) begin
          state_nx = ST_END;
          done_nx  = 1'b1;
          tmo_nx   = 1'b1;
        end else begin
          be_nx = 1'b0;
        end
      end
      ST_RECV: begin
        if (!ack_) begin
          state_nx = ST_HOLD;
          par_nx   = par_in;
          oe_nx    = 1'b0;
        end else if (expire) begin
          state_nx = ST_END;
          done_nx  = 1'b1;
          tmo_nx   = 1'b1;
          perr_nx  = 1'b0;
        end else begin
          rle_nx = 1'b0;
          oe_nx  = 1'b0;
        end
      end
      ST_HOLD: begin
        // rle_ is already high here, so r and odd reflect the latched bus.
        state_nx = ST_END;
        rdata_nx = r;
        perr_nx  = odd ^ par_cap;
        done_nx  = 1'b1;
      end
      ST_END: begin
        state_nx = ST_IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state   <= ST_IDLE;
      a       <= '0;
      rdata   <= '0;
      drcp    <= 1'b0;
      be_     <= 1'b1;
      rle_    <= 1'b1;
      oe_     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      perr    <= 1'b0;
      tmo     <= 1'b0;
      par_cap <= 1'b0;
    end else begin
      state   <= state_nx;
      a       <= a_nx;
      rdata   <= rdata_nx;
      drcp    <= drcp_nx;
      be_     <= be_nx;
      rle_    <= rle_nx;
      oe_     <= oe_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      perr    <= perr_nx;
      tmo     <= tmo_nx;
      par_cap <= par_nx;
    end
  end

endmodule

// File: doc/bus_xfer_ctl.md
BUS_XFER_CTL -- requirements
Module: bus_xfer_ctl

Interface
REQ-001 Parameter WIDTH, default 4: data path width; matches the am2907 slice width.
REQ-002 Parameter TIMEOUT, default 15: maximum number of cycles to wait for ack_ (1..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_  input  1  reset; synchronous, active-low.
REQ-005 req  input  1  transfer request, sampled in IDLE only.
REQ-006 wr  input  1  transfer direction: 1=write (drive bus), 0=read (receive), sampled with req.
REQ-007 wdata  input  WIDTH  write data, captured when req is accepted.
REQ-008 par_in  input  1  expected bus parity for reads, sampled in the ack cycle.
REQ-009 ack_  input  1  active-low slave acknowledge from the bus.
REQ-010 r  input  WIDTH  receiver output of the transceiver.
REQ-011 odd  input  1  transceiver parity output (XOR of the selected data).
REQ-012 a  output  WIDTH  driver-register data to the transceiver.
REQ-013 drcp  output  1  driver-register clock strobe, registered, one clk wide.
REQ-014 be_, rle_, oe_  output  1 each  transceiver bus enable, receiver latch enable and receiver output enable, all active-low.
REQ-015 rdata  output  WIDTH  captured read data.
REQ-016 busy  output  1  high from acceptance until the cycle after done.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 perr, tmo  output  1 each  status of the last transfer; valid with done, held until the next accept.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DRIVE, RECV, HOLD, END; all outputs registered.
REQ-020 IDLE with req=1 and wr=1 SHALL go to LOAD; with req=1 and wr=0 it SHALL go to RECV; on accept, perr and tmo SHALL clear and busy SHALL rise.
REQ-021 LOAD SHALL present a=wdata, pulse drcp=1 for exactly one cycle, then go to DRIVE.
REQ-022 DRIVE SHALL hold be_=0; ack_=0 SHALL go to END.
REQ-023 RECV SHALL hold rle_=0 and oe_=0 (transparent); ack_=0 SHALL capture par_in and go to HOLD.
REQ-024 HOLD SHALL set rle_=1 (latch) with oe_=0, load rdata<=r, set perr=(odd!=captured par_in), then go to END.
REQ-025 END SHALL pulse done=1, return be_=1, rle_=1 and oe_=1, and go to IDLE; busy drops on the following cycle.
REQ-026 A 4-bit wait counter SHALL clear on entry to DRIVE or RECV and increment each cycle ack_=1; when it reaches TIMEOUT-1 with ack_=1, the FSM SHALL go to END with tmo=1, perr=0 and rdata unchanged.
REQ-027 When ack_=0 occurs in the same cycle as the timeout count, ack SHALL win (tmo=0).
REQ-028 req while busy SHALL be ignored; no queuing.
REQ-029 With immediate ack, write latency SHALL be 3 cycles (accept to done) and read latency 3 cycles.
REQ-030 be_=0 and oe_=0 SHALL never be asserted in the same cycle.

Reset
REQ-031 rst_=0 at an edge SHALL force IDLE, a=0, drcp=0, be_=1, rle_=1, oe_=1, rdata=0, busy=0, done=0, perr=0, tmo=0 and counter=0.
REQ-032 Reset mid-transfer SHALL release the bus on the same edge, with no done pulse.

Structure
REQ-033 State encodings and the default TIMEOUT SHALL live in a shared package, bus_xfer_pkg.
REQ-034 The wait counter SHALL be a sub-module, bus_xfer_tmo (clear/enable/expire); everything else is flat.

Verification
REQ-035 The bench SHALL instantiate bus_xfer_ctl together with am2907 (WIDTH=4).
REQ-036 Write: req=1, wr=1, wdata=1010, ack_ low in DRIVE -> drcp pulse, am2907 dreg=1010, bus_ driven while be_=0, odd=0, done at cycle 3, tmo=0.
REQ-037 Read: bus_=1100, par_in=0 -> rdata=0011, perr=0; repeat with bus_=0111, par_in=0 -> rdata=1000, perr=1.
REQ-038 Timeout: read with ack_ held 1 -> done after TIMEOUT cycles in RECV, tmo=1, rdata keeps its prior value 1000, rle_ and oe_ both 1.
REQ-039 Edges: ack_ falls on the TIMEOUT-1 count -> tmo=0; req during busy -> ignored; rst_=0 in DRIVE -> be_=1 next edge, no done.
